// File: rtl/display_pkg.sv
// Shared constants, state encoding and sign helper for the display scheduler
// and its serial binary-to-BCD converter.
package display_pkg;

    localparam int NUM_DIGITS  = 7;
    localparam int BCD_W       = 4;
    localparam int CONV_DIGITS = 10;
    localparam int DIG_W       = NUM_DIGITS * BCD_W;
    localparam int CONV_W      = CONV_DIGITS * BCD_W;

    localparam logic [DIG_W-1:0] SAT_DIGITS = 28'h9999999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_UPDATE
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to 2147483648 as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Source-request / display-output bundle between the datapath and the scheduler.
interface display_scheduler_if #(
    parameter int N_SRC = 4
) ();
    import display_pkg::*;

    localparam int SEL_W = $clog2(N_SRC);

    logic [N_SRC*32-1:0] src_data;
    logic [N_SRC-1:0]    src_req;
    logic                hold;
    logic [DIG_W-1:0]    digits;
    logic                neg;
    logic                ovf;
    logic [SEL_W-1:0]    sel;
    logic                valid;
    logic                busy;

    modport master (
        output src_data, src_req, hold,
        input  digits, neg, ovf, sel, valid, busy
    );

    modport slave (
        input  src_data, src_req, hold,
        output digits, neg, ovf, sel, valid, busy
    );

endinterface

// File: rtl/bcd_serial_converter.sv
// Serial double-dabble: captures a 32-bit magnitude on start and produces
// 10 BCD digits after 32 add-3/shift steps.
module bcd_serial_converter
    import display_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       mag,
    output logic              done,
    output logic [CONV_W-1:0] bcd
);

    logic [CONV_W-1:0] bcd_q, bcd_d;
    logic [CONV_W-1:0] adj;
    logic [31:0]       mag_q, mag_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              run_q, run_d;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < CONV_DIGITS; k++) begin
            if (bcd_q[k*BCD_W +: BCD_W] >= 4'd5) begin
                adj[k*BCD_W +: BCD_W] = bcd_q[k*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    always_comb begin
        bcd_d = bcd_q;
        mag_d = mag_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            bcd_d = '0;
            mag_d = mag;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = {adj[CONV_W-2:0], mag_q[31]};
            mag_d = {mag_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= '0;
            mag_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            mag_q <= mag_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // High during the final shift so the caller can leave SHIFT on that edge.
    assign done = run_q && (cnt_q == 5'd31);
    assign bcd  = bcd_q;

endmodule

// File: rtl/display_scheduler.sv
// Round-robin time-sharing of the 7-digit display between N_SRC 32-bit sources,
// with dwell timing, sign-magnitude BCD conversion and registered outputs.
module display_scheduler
    import display_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    display_scheduler_if.slave bus
);

    localparam int SEL_W = $clog2(N_SRC);
    localparam int CNT_W = $clog2(DWELL);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  nxt_sel_q, nxt_sel_d;
    logic [SEL_W-1:0]  conv_src_q, conv_src_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic              adv_q, adv_d;
    logic              neg_c_q, neg_c_d;
    logic [DIG_W-1:0]  digits_q, digits_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [31:0]       src_word [N_SRC];
    logic [31:0]       cap_word;
    logic              conv_start;
    logic              conv_done;
    logic [CONV_W-1:0] conv_bcd;
    logic [SEL_W-1:0]  cand;
    logic              cand_found;
    logic              adv_req;
    logic              at_boundary;
    logic              wrap;

    for (genvar g = 0; g < N_SRC; g++) begin : g_word
        assign src_word[g] = bus.src_data[g*32 +: 32];
    end

    assign cap_word   = src_word[nxt_sel_q];
    assign conv_start = (state_q == ST_LOAD);

    bcd_serial_converter u_conv (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .mag   (abs32(cap_word)),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Nearest requester after the current select; smallest offset wins.
    always_comb begin
        cand       = nxt_sel_q;
        cand_found = 1'b0;
        for (int i = N_SRC - 1; i >= 1; i--) begin
            if (bus.src_req[SEL_W'((int'(nxt_sel_q) + i) % N_SRC)]) begin
                cand       = SEL_W'((int'(nxt_sel_q) + i) % N_SRC);
                cand_found = 1'b1;
            end
        end
    end

    assign wrap        = (dwell_q == CNT_W'(DWELL - 1));
    assign at_boundary = (state_q == ST_IDLE) || (state_q == ST_UPDATE);
    assign adv_req     = adv_q || (!bus.src_req[nxt_sel_q] && cand_found);

    always_comb begin
        state_d    = state_q;
        nxt_sel_d  = nxt_sel_q;
        conv_src_d = conv_src_q;
        sel_d      = sel_q;
        dwell_d    = dwell_q;
        adv_d      = adv_q;
        neg_c_d    = neg_c_q;
        digits_d   = digits_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;

        if (!bus.hold) begin
            dwell_d = wrap ? '0 : dwell_q + CNT_W'(1);
            if (wrap) begin
                adv_d = 1'b1;
            end
            // Advances land only between conversions so sel always names the source shown.
            if (at_boundary && adv_req) begin
                if (cand_found) begin
                    nxt_sel_d = cand;
                end
                adv_d   = 1'b0;
                dwell_d = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|bus.src_req) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                neg_c_d    = cap_word[31];
                conv_src_d = nxt_sel_q;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (conv_done) begin
                    state_d = ST_UPDATE;
                    busy_d  = 1'b0;
                end
            end
            ST_UPDATE: begin
                if (|conv_bcd[CONV_W-1:DIG_W]) begin
                    ovf_d    = 1'b1;
                    digits_d = SAT_DIGITS;
                end else begin
                    ovf_d    = 1'b0;
                    digits_d = conv_bcd[DIG_W-1:0];
                end
                neg_d   = neg_c_q && (|conv_bcd);
                sel_d   = conv_src_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            nxt_sel_q  <= '0;
            conv_src_q <= '0;
            sel_q      <= '0;
            dwell_q    <= '0;
            adv_q      <= 1'b0;
            neg_c_q    <= 1'b0;
            digits_q   <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_sel_q  <= nxt_sel_d;
            conv_src_q <= conv_src_d;
            sel_q      <= sel_d;
            dwell_q    <= dwell_d;
            adv_q      <= adv_d;
            neg_c_q    <= neg_c_d;
            digits_q   <= digits_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.digits = digits_q;
    assign bus.neg    = neg_q;
    assign bus.ovf    = ovf_q;
    assign bus.sel    = sel_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: expected display words are queued
// when stimulus is applied and popped when valid pulses.
module tb_display_scheduler;

    localparam int DWELL = 100;

    typedef struct packed {
        logic [27:0] d;
        logic        n;
        logic        o;
        logic [1:0]  s;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] src_w [4];
    int          total   = 0;
    int          bad     = 0;
    int          cyc_cnt = 0;
    exp_t        exp_q[$];

    display_scheduler_if #(.N_SRC(4)) bus ();

    assign bus.src_data = {src_w[3], src_w[2], src_w[1], src_w[0]};

    display_scheduler #(.N_SRC(4), .DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic exp_t model(input logic [31:0] x, input logic [1:0] s);
        exp_t        e;
        logic [63:0] mag;
        mag = x[31] ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
        e.s = s;
        e.n = x[31];
        e.o = (mag > 64'd9_999_999);
        e.d = 28'h9999999;
        if (!e.o) begin
            for (int k = 0; k < 7; k++) begin
                e.d[4*k +: 4] = 4'(mag % 64'd10);
                mag = mag / 64'd10;
            end
        end
        return e;
    endfunction

    function automatic exp_t observed();
        return {bus.digits, bus.neg, bus.ovf, bus.sel};
    endfunction

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_sources(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
        src_w[0] = a;
        src_w[1] = b;
        src_w[2] = c;
        src_w[3] = d;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.src_req = '0;
        bus.hold    = 1'b0;
        set_sources(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        total++;
        if ({bus.digits, bus.neg, bus.ovf, bus.sel, bus.valid, bus.busy} !== 34'd0) begin
            bad++;
            $display("FAIL reset_state: got digits=%h neg=%b ovf=%b sel=%0d valid=%b busy=%b, want all zero",
                     bus.digits, bus.neg, bus.ovf, bus.sel, bus.valid, bus.busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        int   n;
        bit   seen;
        src_w[0] = 32'd1234567;
        exp_q.push_back(model(32'd1234567, 2'd0));
        exp_q.push_back(model(32'd1234567, 2'd0));
        bus.src_req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.busy === 1'b1);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = (bus.valid === 1'b1);
        end
        total++;
        if (n != 34) begin
            bad++;
            $display("FAIL latency: got %0d cycles from LOAD to valid, want 34", n);
        end
        e = exp_q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL basic_value: got %h, want %h", observed(), e);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = (bus.valid === 1'b1);
        end
        total++;
        if (n != 35) begin
            bad++;
            $display("FAIL refresh_period: got %0d cycles between valids, want 35", n);
        end
        e = exp_q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL refresh_value: got %h, want %h", observed(), e);
        end
    endtask

    task automatic test_values();
        logic [31:0] vals [7];
        exp_t        e;
        bit          ok;
        vals = '{32'hFFFFFF85, 32'd0, 32'd10_000_000, 32'h80000000,
                 32'd9_999_999, 32'hFF676981, 32'h7FFFFFFF};
        foreach (vals[j]) begin
            src_w[0] = vals[j];
            exp_q.push_back(model(vals[j], 2'd0));
            wait_valid(ok);
            wait_valid(ok);
            if (!ok) begin
                total++;
                bad++;
                $display("FAIL values_timeout: got no valid for %h, want a valid pulse", vals[j]);
            end
            e = exp_q.pop_front();
            total++;
            if (observed() !== e) begin
                bad++;
                $display("FAIL value_%0d: got %h, want %h for input %h", j, observed(), e, vals[j]);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t       e;
        logic [1:0] prev_sel;
        logic [1:0] last_sel;
        bit         first;
        int         viol;
        reset = 1'b1;
        set_sources(32'd11, 32'hFFFFFFEA, 32'd33, 32'd44_444_444);
        bus.src_req = 4'b1011;
        exp_q.push_back(model(src_w[0], 2'd0));
        exp_q.push_back(model(src_w[1], 2'd1));
        exp_q.push_back(model(src_w[3], 2'd3));
        exp_q.push_back(model(src_w[0], 2'd0));
        @(negedge clk);
        reset    = 1'b0;
        prev_sel = 2'd0;
        last_sel = 2'd0;
        first    = 1'b1;
        viol     = 0;
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (bus.sel !== prev_sel && bus.valid !== 1'b1) viol++;
            prev_sel = bus.sel;
            if (bus.valid === 1'b1 && (first || bus.sel !== last_sel)) begin
                first    = 1'b0;
                last_sel = bus.sel;
                e = exp_q.pop_front();
                total++;
                if (observed() !== e) begin
                    bad++;
                    $display("FAIL rotation_step: got %h, want %h", observed(), e);
                end
            end
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL rotation_timeout: got %0d steps outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL sel_boundary: got %0d sel changes without valid, want 0", viol);
        end
    endtask

    task automatic test_hold();
        logic [1:0] held;
        int         changes;
        int         pulses;
        bit         ok;
        bit         moved;
        bus.hold = 1'b1;
        wait_valid(ok);
        wait_valid(ok);
        held    = bus.sel;
        changes = 0;
        pulses  = 0;
        for (int i = 0; i < 350; i++) begin
            @(negedge clk);
            if (bus.sel !== held) changes++;
            if (bus.valid === 1'b1) pulses++;
        end
        total++;
        if (changes != 0) begin
            bad++;
            $display("FAIL hold_freeze: got %0d cycles with sel moved, want 0", changes);
        end
        total++;
        if (pulses < 9) begin
            bad++;
            $display("FAIL hold_refresh: got %0d valid pulses in 350 cycles, want at least 9", pulses);
        end
        bus.hold = 1'b0;
        moved = 1'b0;
        for (int i = 0; i < 400 && !moved; i++) begin
            @(negedge clk);
            moved = (bus.sel !== held);
        end
        total++;
        if (!moved) begin
            bad++;
            $display("FAIL hold_release: got sel stuck at %0d, want advance after release", held);
        end
    endtask

    task automatic test_drop();
        exp_t e;
        int   rel;
        bit   ok;
        bit   seen;
        reset = 1'b1;
        set_sources(32'd11, 32'hFFFFFFEA, 32'd33, 32'd44_444_444);
        bus.src_req = 4'b1011;
        exp_q.push_back(model(src_w[0], 2'd0));
        exp_q.push_back(model(src_w[1], 2'd1));
        @(negedge clk);
        reset = 1'b0;
        rel   = cyc_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.busy === 1'b1);
        end
        repeat (10) @(negedge clk);
        bus.src_req = 4'b1010;
        wait_valid(ok);
        e = exp_q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL drop_finish: got %h, want %h", observed(), e);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL drop_advance: got %h, want %h", observed(), e);
        end
        total++;
        if (!ok || (cyc_cnt - rel) >= DWELL) begin
            bad++;
            $display("FAIL drop_early: got second valid %0d cycles after start, want under %0d", cyc_cnt - rel, DWELL);
        end
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        int   n;
        bit   ok;
        bit   seen;
        reset = 1'b1;
        set_sources(32'd1234567, 32'd0, 32'd0, 32'd44_444_444);
        bus.src_req = 4'b1000;
        exp_q.push_back(model(src_w[3], 2'd3));
        @(negedge clk);
        reset = 1'b0;
        wait_valid(ok);
        e = exp_q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL pre_reset_value: got %h, want %h", observed(), e);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.busy === 1'b1);
        end
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({bus.digits, bus.neg, bus.ovf, bus.sel, bus.valid, bus.busy} !== 34'd0) begin
            bad++;
            $display("FAIL mid_shift_reset: got digits=%h neg=%b ovf=%b sel=%0d valid=%b busy=%b, want all zero",
                     bus.digits, bus.neg, bus.ovf, bus.sel, bus.valid, bus.busy);
        end
        bus.src_req = 4'b0001;
        exp_q.push_back(model(src_w[0], 2'd0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = (bus.valid === 1'b1);
        end
        total++;
        if (n != 35) begin
            bad++;
            $display("FAIL restart_latency: got first valid %0d cycles after release, want 35", n);
        end
        e = exp_q.pop_front();
        total++;
        if (observed() !== e) begin
            bad++;
            $display("FAIL restart_value: got %h, want %h", observed(), e);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish by 500us, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_rotation();
        test_hold();
        test_drop();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
